// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - state encoding and command constants for the QSPI memory controller
package qspi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_MODE,
      ST_DUMMY,
      ST_RDATA,
      ST_WDATA,
      ST_FIN
   } qspi_state_t;

   typedef enum logic [1:0] {
      TGT_FLASH,
      TGT_RAM_A,
      TGT_RAM_B
   } qspi_target_t;

   localparam logic [7:0] CMD_READ     = 8'h0B;
   localparam logic [7:0] CMD_WRITE    = 8'h02;
   localparam logic [7:0] FLASH_MODE   = 8'hA0;
   localparam int         ADDR_NIBBLES = 6;

endpackage

// File: rtl/qspi_mem_ctrl.sv
// rtl/qspi_mem_ctrl.sv - nibble-serial QSPI master for one quad-read flash and two PSRAMs
module qspi_mem_ctrl
   import qspi_pkg::*;
#(
   parameter int DUMMY_NIBBLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        we,
   input  logic [24:0] addr,
   input  logic [1:0]  len,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        qspi_clk,
   output logic [3:0]  qspi_data_out,
   output logic [3:0]  qspi_data_oe,
   input  logic [3:0]  qspi_data_in,
   output logic        qspi_flash_select,
   output logic        qspi_ram_a_select,
   output logic        qspi_ram_b_select
);

   qspi_state_t  state_q, state_d;
   qspi_target_t target_q;
   logic         phase_q;
   logic [4:0]   cnt_q;
   logic [31:0]  sr_q;
   logic [23:0]  addr_q;
   logic [31:0]  wdata_q;
   logic [1:0]   len_q;
   logic         we_q;
   logic         err_q;
   logic [31:0]  rdata_q;

   logic         accept;
   logic         serial;
   logic         last_nibble;
   logic [2:0]   rd_idx;
   logic [4:0]   rd_bit;
   logic [23:0]  addr_load;

   // Only IDLE accepts a request; FIN is a mandatory gap that keeps the selects high.
   assign accept      = (state_q == ST_IDLE) && start;
   assign serial      = (state_q != ST_IDLE) && (state_q != ST_FIN);
   // A phase ends on the high half of the last nibble's serial clock.
   assign last_nibble = phase_q && (cnt_q == 5'd0);
   // Data nibble index j counts up as cnt_q counts down; even j is the high nibble of byte j/2.
   assign rd_idx      = {len_q, 1'b1} - cnt_q[2:0];
   assign rd_bit      = {rd_idx[2:1], ~rd_idx[0], 2'b00};
   // Flash enters ADDR straight from IDLE, before addr_q has been captured.
   assign addr_load   = (state_q == ST_IDLE) ? addr[23:0] : addr_q;
   assign rdata       = rdata_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state sequencing of the command / address / data phases
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = addr[24] ? ST_CMD : (we ? ST_FIN : ST_ADDR);
         ST_CMD:   if (last_nibble) state_d = ST_ADDR;
         ST_ADDR:  if (last_nibble) state_d = (target_q == TGT_FLASH) ? ST_MODE :
                                               (we_q ? ST_WDATA : ST_DUMMY);
         ST_MODE:  if (last_nibble) state_d = ST_DUMMY;
         ST_DUMMY: if (last_nibble) state_d = ST_RDATA;
         ST_RDATA: if (last_nibble) state_d = ST_FIN;
         ST_WDATA: if (last_nibble) state_d = ST_FIN;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Request capture, nibble shift register, phase counter and read assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= 1'b0;
         cnt_q    <= '0;
         sr_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         len_q    <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         target_q <= TGT_FLASH;
      end else begin
         if (accept) begin
            we_q     <= we;
            len_q    <= len;
            wdata_q  <= wdata;
            err_q    <= we && !addr[24];
            addr_q   <= addr[24] ? {1'b0, addr[22:0]} : addr[23:0];
            target_q <= !addr[24] ? TGT_FLASH : (addr[23] ? TGT_RAM_B : TGT_RAM_A);
            if (!we) rdata_q <= '0;
         end
         if ((state_q == ST_RDATA) && !phase_q) rdata_q[rd_bit +: 4] <= qspi_data_in;
         if (state_d != state_q) begin
            phase_q <= 1'b0;
            case (state_d)
               ST_CMD:   begin sr_q <= {(we ? CMD_WRITE : CMD_READ), 24'h0}; cnt_q <= 5'd1; end
               ST_ADDR:  begin sr_q <= {addr_load, 8'h0}; cnt_q <= 5'(ADDR_NIBBLES - 1); end
               ST_MODE:  begin sr_q <= {FLASH_MODE, 24'h0}; cnt_q <= 5'd1; end
               ST_DUMMY: begin sr_q <= '0; cnt_q <= 5'(DUMMY_NIBBLES - 1); end
               ST_RDATA: begin sr_q <= '0; cnt_q <= {2'b00, len_q, 1'b1}; end
               ST_WDATA: begin
                  sr_q  <= {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]};
                  cnt_q <= {2'b00, len_q, 1'b1};
               end
               default:  begin sr_q <= '0; cnt_q <= '0; end
            endcase
         end else if (serial) begin
            phase_q <= ~phase_q;
            if (phase_q) begin
               sr_q  <= {sr_q[27:0], 4'h0};
               cnt_q <= cnt_q - 5'd1;
            end
         end
      end
   end

   // Bus pins and status derived from the current state
   always_comb begin
      busy              = 1'b0;
      done              = 1'b0;
      err               = 1'b0;
      qspi_clk          = 1'b0;
      qspi_data_out     = 4'h0;
      qspi_data_oe      = 4'h0;
      qspi_flash_select = 1'b1;
      qspi_ram_a_select = 1'b1;
      qspi_ram_b_select = 1'b1;
      if (state_q == ST_FIN) begin
         done = 1'b1;
         err  = err_q;
      end else if (serial) begin
         busy     = 1'b1;
         qspi_clk = phase_q;
         case (target_q)
            TGT_FLASH: qspi_flash_select = 1'b0;
            TGT_RAM_A: qspi_ram_a_select = 1'b0;
            default:   qspi_ram_b_select = 1'b0;
         endcase
         if ((state_q == ST_CMD) || (state_q == ST_ADDR) ||
             (state_q == ST_MODE) || (state_q == ST_WDATA)) begin
            qspi_data_oe  = 4'hF;
            qspi_data_out = sr_q[31:28];
         end
      end
   end

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// tb/tb_qspi_mem_ctrl.sv - randomized self-checking bench with a QSPI slave and memory reference model
module tb_qspi_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        we = 1'b0;
   logic [24:0] addr = '0;
   logic [1:0]  len = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        busy, done, err, qspi_clk;
   logic [3:0]  qspi_data_out, qspi_data_oe;
   logic [3:0]  qspi_data_in = 4'h0;
   logic        qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select;

   qspi_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .we(we), .addr(addr), .len(len),
      .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
      .qspi_clk(qspi_clk), .qspi_data_out(qspi_data_out), .qspi_data_oe(qspi_data_oe),
      .qspi_data_in(qspi_data_in), .qspi_flash_select(qspi_flash_select),
      .qspi_ram_a_select(qspi_ram_a_select), .qspi_ram_b_select(qspi_ram_b_select)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Environment memory contents: flash is a fixed pattern plus preloaded overrides.
   logic [7:0] rom_over [int];
   logic [7:0] sl_ram_a [int];
   logic [7:0] sl_ram_b [int];
   logic [7:0] ref_a [int];
   logic [7:0] ref_b [int];

   function automatic logic [7:0] flash_byte(input int a);
      if (rom_over.exists(a)) return rom_over[a];
      return 8'(a ^ (a >> 8) ^ (a >> 16) ^ 'h5A);
   endfunction

   function automatic logic [7:0] ram_init(input int bank, input int a);
      return 8'((a * 13) ^ (bank != 0 ? 'hC3 : 'h3C));
   endfunction

   function automatic logic [7:0] sl_rd(input int bank, input int a);
      if (bank == 0) return sl_ram_a.exists(a) ? sl_ram_a[a] : ram_init(0, a);
      return sl_ram_b.exists(a) ? sl_ram_b[a] : ram_init(1, a);
   endfunction

   function automatic logic [7:0] ref_rd(input int bank, input int a);
      if (bank == 0) return ref_a.exists(a) ? ref_a[a] : ram_init(0, a);
      return ref_b.exists(a) ? ref_b[a] : ram_init(1, a);
   endfunction

   // QSPI slave: decodes the serial stream by clock index since select fell.
   int          nib_cnt = 0;
   logic [7:0]  s_cmd = '0, s_mode = '0;
   logic [23:0] s_addr = '0;
   logic [3:0]  s_hi = '0;
   logic [3:0]  bus_nibs [$];
   int          rise_cnt = 0;
   logic [2:0]  sel_mask = '0;

   always @(posedge qspi_flash_select or posedge qspi_ram_a_select or posedge qspi_ram_b_select)
      nib_cnt = 0;

   always @(negedge qspi_flash_select) sel_mask[0] = 1'b1;
   always @(negedge qspi_ram_a_select) sel_mask[1] = 1'b1;
   always @(negedge qspi_ram_b_select) sel_mask[2] = 1'b1;

   always @(posedge qspi_clk) begin : slave_rx
      int d, idx;
      rise_cnt++;
      if (nib_cnt == 0) bus_nibs.delete();
      if (qspi_data_oe == 4'hF) bus_nibs.push_back(qspi_data_out);
      if (!qspi_flash_select) begin
         if (nib_cnt < 6) s_addr = {s_addr[19:0], qspi_data_out};
         else if (nib_cnt < 8) s_mode = {s_mode[3:0], qspi_data_out};
      end else if (!qspi_ram_a_select || !qspi_ram_b_select) begin
         if (nib_cnt < 2) s_cmd = {s_cmd[3:0], qspi_data_out};
         else if (nib_cnt < 8) s_addr = {s_addr[19:0], qspi_data_out};
         else if (s_cmd == 8'h02) begin
            d = nib_cnt - 8;
            idx = (int'(s_addr[22:0]) + d / 2) & 'h7FFFFF;
            if (d[0] == 1'b0) s_hi = qspi_data_out;
            else if (!qspi_ram_a_select) sl_ram_a[idx] = {s_hi, qspi_data_out};
            else sl_ram_b[idx] = {s_hi, qspi_data_out};
         end
      end
      nib_cnt++;
   end

   always @(negedge qspi_clk) begin : slave_tx
      int d;
      logic [7:0] b;
      b = 8'h00;
      d = nib_cnt - 12;
      if (nib_cnt >= 12) begin
         if (!qspi_flash_select) b = flash_byte((int'(s_addr) + d / 2) & 'hFFFFFF);
         else if (s_cmd == 8'h0B && !qspi_ram_a_select)
            b = sl_rd(0, (int'(s_addr[22:0]) + d / 2) & 'h7FFFFF);
         else if (s_cmd == 8'h0B && !qspi_ram_b_select)
            b = sl_rd(1, (int'(s_addr[22:0]) + d / 2) & 'h7FFFFF);
      end
      qspi_data_in = d[0] ? b[3:0] : b[7:4];
   end

   logic [31:0] exp_rdata = '0;

   // One request: the expectation is built from the transaction rules, then the DUT is run.
   task automatic do_req(input logic w, input logic [24:0] a, input logic [1:0] l,
                         input logic [31:0] wd, input int glitch);
      int m, exp_done, done_cyc, base, mask, bank;
      logic flash_wr, got_err, busy_ok, got_busy;
      logic [2:0] exp_sel;
      flash_wr = w && !a[24];
      bank     = a[23] ? 1 : 0;
      mask     = a[24] ? 'h7FFFFF : 'hFFFFFF;
      base     = a[24] ? int'(a[22:0]) : int'(a[23:0]);
      m        = flash_wr ? 0 : (w ? 8 : 12) + 2 * (int'(l) + 1);
      exp_done = flash_wr ? 1 : 2 * m + 1;
      exp_sel  = flash_wr ? 3'b000 : (!a[24] ? 3'b001 : (a[23] ? 3'b100 : 3'b010));
      if (!w) begin
         exp_rdata = '0;
         for (int i = 0; i <= int'(l); i++)
            exp_rdata[8*i +: 8] = a[24] ? ref_rd(bank, (base + i) & mask)
                                        : flash_byte((base + i) & mask);
      end else if (a[24]) begin
         for (int i = 0; i <= int'(l); i++)
            if (bank == 0) ref_a[(base + i) & mask] = wd[8*i +: 8];
            else           ref_b[(base + i) & mask] = wd[8*i +: 8];
      end

      @(posedge clk); #1;
      we = w; addr = a; len = l; wdata = wd; start = 1'b1;
      rise_cnt = 0; sel_mask = '0;
      done_cyc = -1; got_err = 1'b0; got_busy = 1'b1; busy_ok = 1'b1;
      for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
         @(posedge clk); #1;
         if (c == 1) start = 1'b0;
         if (glitch > 0 && c == glitch) begin
            start = 1'b1; we = ~w; addr = 25'($urandom); wdata = $urandom; len = 2'($urandom);
         end
         if (glitch > 0 && c == glitch + 1) start = 1'b0;
         if (done) begin
            done_cyc = c; got_err = err; got_busy = busy;
         end else if (!busy) busy_ok = 1'b0;
      end
      check("done_cycle", 32'(done_cyc), 32'(exp_done));
      check("err", 32'(got_err), 32'(flash_wr));
      check("busy_in_fin", 32'(got_busy), 32'd0);
      check("busy_span", 32'(busy_ok), 32'd1);
      check("qclk_rises", 32'(rise_cnt), 32'(m));
      check("selects_used", 32'(sel_mask), 32'(exp_sel));
      check("rdata", rdata, exp_rdata);
      @(posedge clk); #1;
      check("done_pulse", 32'(done), 32'd0);
   endtask

   initial begin : main
      logic [31:0] pk;
      int bad;
      logic [24:0] ra;
      int tgt;
      rom_over[32'h10] = 8'h11; rom_over[32'h11] = 8'h22;
      rom_over[32'h12] = 8'h33; rom_over[32'h13] = 8'h44;

      repeat (3) @(posedge clk);
      #1;
      check("rst_selects", 32'({qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select}), 32'h7);
      check("rst_qclk_oe_out", 32'({qspi_clk, qspi_data_oe, qspi_data_out}), 32'h0);
      check("rst_status", 32'({busy, done, err}), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;

      // Flash quad read of the preloaded bytes.
      do_req(1'b0, 25'h0000010, 2'd3, 32'h0, 0);
      pk = '0;
      for (int i = 0; i < 8; i++) if (i < bus_nibs.size()) pk = {pk[27:0], bus_nibs[i]};
      check("flash_bus_nibs", pk, 32'h000010A0);
      check("flash_rdata_const", rdata, 32'h44332211);

      // RAM A write.
      do_req(1'b1, 25'h1000020, 2'd1, 32'h0000BEEF, 0);
      check("ram_a_20", 32'(sl_rd(0, 'h20)), 32'hEF);
      check("ram_a_21", 32'(sl_rd(0, 'h21)), 32'hBE);

      // RAM B write then read back.
      do_req(1'b1, 25'h1800100, 2'd3, 32'hCAFEF00D, 0);
      do_req(1'b0, 25'h1800100, 2'd3, 32'h0, 0);
      check("ram_b_readback", rdata, 32'hCAFEF00D);
      bad = 0;
      for (int i = 'h100; i < 'h104; i++) if (sl_ram_a.exists(i)) bad++;
      check("ram_a_untouched", 32'(bad), 32'd0);

      // Flash write is rejected without touching the bus.
      do_req(1'b1, 25'h0000040, 2'd0, 32'h12345678, 0);

      // A start pulse while busy is ignored.
      do_req(1'b0, 25'h1000020, 2'd1, 32'h0, 5);
      check("glitch_rdata", rdata, 32'h0000BEEF);

      // Reset during the dummy phase of a flash read.
      @(posedge clk); #1;
      we = 1'b0; addr = 25'h0000010; len = 2'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_selects", 32'({qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select}), 32'h7);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_qclk", 32'(qspi_clk), 32'd0);
      check("midrst_rdata", rdata, 32'h0);
      exp_rdata = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_req(1'b0, 25'h0000010, 2'd3, 32'h0, 0);

      // Randomized mix across all three devices.
      for (int n = 0; n < 40; n++) begin
         tgt = $urandom_range(0, 2);
         if (tgt == 0) ra = {1'b0, 24'($urandom)};
         else ra = {1'b1, (tgt == 2), 23'h150000 + 23'($urandom_range(0, 31))};
         do_req(1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)), $urandom, 0);
      end

      bad = 0;
      foreach (ref_a[k]) if (sl_rd(0, k) !== ref_a[k]) bad++;
      foreach (ref_b[k]) if (sl_rd(1, k) !== ref_b[k]) bad++;
      check("ram_consistency", 32'(bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
